// File: rtl/ctrl_pkg.sv
// Shared opcode/funct codes, output encodings and the control word layout
// for pipelined_control_unit.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_NOOP  = 6'h00;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;

    typedef enum logic [1:0] {
        OSEL_ALU = 2'b00,
        OSEL_LUI = 2'b01,
        OSEL_LO  = 2'b10,
        OSEL_HI  = 2'b11
    } out_sel_e;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'b000,
        ALU_AND   = 3'b010,
        ALU_OR    = 3'b011,
        ALU_XOR   = 3'b100,
        ALU_SLT   = 3'b101,
        ALU_RTYPE = 3'b111
    } alu_mid_e;

    typedef struct packed {
        logic     reg_write;
        logic     reg_dst;
        logic     alu_src_a;
        logic     mem_write;
        logic     mem_read;
        logic     mem_to_reg;
        logic     beq;
        logic     bne;
        logic     jump;
        logic     se_ze;
        logic     start_mult;
        logic     mult_sign;
        out_sel_e out_select;
        alu_mid_e alu_mid;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOOP = '0;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/funct decoder producing the control word plus
// multiply, HI/LO-read and illegal-opcode flags.
module control_decode
    import ctrl_pkg::*;
(
    input  logic [5:0]  op_code,
    input  logic [5:0]  funct,
    output ctrl_word_t  ctrl,
    output logic        is_mult,
    output logic        is_hilo,
    output logic        illegal
);

    // Main decode table; unlisted opcodes fall back to the all-zero NOOP word.
    always_comb begin
        ctrl    = CTRL_NOOP;
        is_mult = 1'b0;
        is_hilo = 1'b0;
        illegal = 1'b0;
        case (op_code)
            OP_RTYPE: begin
                case (funct)
                    FN_NOOP: ctrl = CTRL_NOOP;
                    FN_MFHI: begin
                        ctrl.reg_write  = 1'b1;
                        ctrl.reg_dst    = 1'b1;
                        ctrl.out_select = OSEL_HI;
                        is_hilo         = 1'b1;
                    end
                    FN_MFLO: begin
                        ctrl.reg_write  = 1'b1;
                        ctrl.reg_dst    = 1'b1;
                        ctrl.out_select = OSEL_LO;
                        is_hilo         = 1'b1;
                    end
                    FN_MULT: begin
                        ctrl.start_mult = 1'b1;
                        ctrl.mult_sign  = 1'b1;
                        is_mult         = 1'b1;
                    end
                    FN_MULTU: begin
                        ctrl.start_mult = 1'b1;
                        is_mult         = 1'b1;
                    end
                    default: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.reg_dst   = 1'b1;
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_mid   = ALU_RTYPE;
                    end
                endcase
            end
            OP_J: ctrl.jump = 1'b1;
            OP_BEQ, OP_BNE: begin
                ctrl.beq       = (op_code == OP_BEQ);
                ctrl.bne       = (op_code == OP_BNE);
                ctrl.alu_src_a = 1'b1;
                ctrl.se_ze     = 1'b1;
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.reg_write = 1'b1;
                ctrl.se_ze     = 1'b1;
            end
            OP_SLTI, OP_SLTIU: begin
                ctrl.reg_write = 1'b1;
                ctrl.se_ze     = 1'b1;
                ctrl.alu_mid   = ALU_SLT;
            end
            OP_ANDI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_mid   = ALU_AND;
            end
            OP_ORI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_mid   = ALU_OR;
            end
            OP_XORI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_mid   = ALU_XOR;
            end
            OP_LUI: begin
                ctrl.reg_write  = 1'b1;
                ctrl.out_select = OSEL_LUI;
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.se_ze      = 1'b1;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.se_ze     = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Registered, valid/ready control unit with multiply-latency interlock.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN (illegal-opcode flag and sticky stall).
module pipelined_control_unit
    import ctrl_pkg::*;
#(
    parameter int MULT_LATENCY = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic       mem_write,
    output logic       mem_read,
    output logic       mem_to_reg,
    output logic       beq,
    output logic       bne,
    output logic       jump,
    output logic       se_ze,
    output logic       start_mult,
    output logic       mult_sign,
    output logic [1:0] out_select,
    output logic [2:0] alu_mid,
    output logic       mult_busy,
    output logic       illegal_op
);

    localparam int CNT_W = (MULT_LATENCY > 0) ? $clog2(MULT_LATENCY + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    ctrl_word_t       dec_word_s;
    logic             dec_mult_s;
    logic             dec_hilo_s;
    logic             dec_illegal_s;
    logic             hazard_s;
    logic             accept_s;

    ctrl_word_t       word_q, word_d;
    logic             out_valid_q, out_valid_d;
    logic             illegal_q, illegal_d;
    logic             trap_q, trap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    control_decode u_decode (
        .op_code (op_code),
        .funct   (funct),
        .ctrl    (dec_word_s),
        .is_mult (dec_mult_s),
        .is_hilo (dec_hilo_s),
        .illegal (dec_illegal_s)
    );

    assign mult_busy = (cnt_q != '0);
    assign hazard_s  = mult_busy & in_valid & (dec_mult_s | dec_hilo_s);
    assign in_ready  = (~out_valid_q | out_ready) & ~hazard_s & ~trap_q;
    assign accept_s  = in_valid & in_ready;

    // Output register, interlock counter and sticky trap next-state.
    always_comb begin
        word_d      = word_q;
        out_valid_d = out_valid_q;
        illegal_d   = illegal_q;
        cnt_d       = cnt_q;
        trap_d      = trap_q;
        if (accept_s) begin
            word_d      = dec_word_s;
            out_valid_d = 1'b1;
            illegal_d   = TRAP_EN & dec_illegal_s;
            trap_d      = trap_q | (TRAP_EN & dec_illegal_s);
        end else if (out_ready) begin
            // Drained with nothing new: park the word at NOOP so flags never linger.
            word_d      = CTRL_NOOP;
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end else begin
            word_d      = word_q;
        end
        if (accept_s & dec_mult_s) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q      <= CTRL_NOOP;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            trap_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            word_q      <= word_d;
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            trap_q      <= trap_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign illegal_op = illegal_q;
    assign reg_write  = word_q.reg_write;
    assign reg_dst    = word_q.reg_dst;
    assign alu_src_a  = word_q.alu_src_a;
    assign mem_write  = word_q.mem_write;
    assign mem_read   = word_q.mem_read;
    assign mem_to_reg = word_q.mem_to_reg;
    assign beq        = word_q.beq;
    assign bne        = word_q.bne;
    assign jump       = word_q.jump;
    assign se_ze      = word_q.se_ze;
    assign start_mult = word_q.start_mult;
    assign mult_sign  = word_q.mult_sign;
    assign out_select = word_q.out_select;
    assign alu_mid    = word_q.alu_mid;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Self-checking bench for pipelined_control_unit: instruction-level model
// plus directed sequences with literal expectations.
module tb_pipelined_control_unit;

    localparam int LAT = 4;
`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [5:0] op_code, funct;
    logic reg_write, reg_dst, alu_src_a, mem_write, mem_read, mem_to_reg;
    logic beq, bne, jump, se_ze, start_mult, mult_sign, mult_busy, illegal_op;
    logic [1:0] out_select;
    logic [2:0] alu_mid;
    logic [16:0] act_word;

    int n_chk = 0;
    int n_fail = 0;
    int stalls;

    pipelined_control_unit #(.MULT_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op_code(op_code), .funct(funct), .out_valid(out_valid), .out_ready(out_ready),
        .reg_write(reg_write), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
        .mem_write(mem_write), .mem_read(mem_read), .mem_to_reg(mem_to_reg),
        .beq(beq), .bne(bne), .jump(jump), .se_ze(se_ze),
        .start_mult(start_mult), .mult_sign(mult_sign), .out_select(out_select),
        .alu_mid(alu_mid), .mult_busy(mult_busy), .illegal_op(illegal_op)
    );

    always #5 clk = ~clk;

    assign act_word = {reg_write, reg_dst, alu_src_a, mem_write, mem_read, mem_to_reg,
                       beq, bne, jump, se_ze, start_mult, mult_sign, out_select, alu_mid};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected word per instruction, order {rw,rd,asa,mw,mr,m2r,beq,bne,j,se,sm,ms,os[1:0],am[2:0]}
    function automatic logic [16:0] ref_word(input logic [5:0] op, input logic [5:0] fn);
        logic rw, rd, asa, mw, mr, m2r, bq, bn, j, se, sm, ms;
        logic [1:0] os;
        logic [2:0] am;
        {rw, rd, asa, mw, mr, m2r, bq, bn, j, se, sm, ms} = 12'b0;
        os = 2'b00;
        am = 3'b000;
        case (op)
            6'h00: case (fn)
                6'h00: ;
                6'h10: begin rw = 1'b1; rd = 1'b1; os = 2'b11; end
                6'h12: begin rw = 1'b1; rd = 1'b1; os = 2'b10; end
                6'h18: begin sm = 1'b1; ms = 1'b1; end
                6'h19: begin sm = 1'b1; end
                default: begin rw = 1'b1; rd = 1'b1; asa = 1'b1; am = 3'b111; end
            endcase
            6'h02: j = 1'b1;
            6'h04: begin bq = 1'b1; asa = 1'b1; se = 1'b1; end
            6'h05: begin bn = 1'b1; asa = 1'b1; se = 1'b1; end
            6'h08, 6'h09: begin rw = 1'b1; se = 1'b1; end
            6'h0A, 6'h0B: begin rw = 1'b1; se = 1'b1; am = 3'b101; end
            6'h0C: begin rw = 1'b1; am = 3'b010; end
            6'h0D: begin rw = 1'b1; am = 3'b011; end
            6'h0E: begin rw = 1'b1; am = 3'b100; end
            6'h0F: begin rw = 1'b1; os = 2'b01; end
            6'h23: begin rw = 1'b1; mr = 1'b1; m2r = 1'b1; se = 1'b1; end
            6'h2B: begin mw = 1'b1; se = 1'b1; end
            default: ;
        endcase
        return {rw, rd, asa, mw, mr, m2r, bq, bn, j, se, sm, ms, os, am};
    endfunction

    function automatic logic ref_illegal(input logic [5:0] op);
        return !(op inside {6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
                            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B});
    endfunction

    // Instruction-level model: one pending word, time of last multiply accept, trap flag.
    logic        m_valid, m_ill, m_trap, m_has_mult;
    logic [16:0] m_word;
    int          m_cyc, m_mult_at;

    function automatic logic m_busy();
        return m_has_mult && ((m_cyc - m_mult_at) < LAT);
    endfunction

    function automatic logic m_ready();
        logic mulhi;
        mulhi = (op_code == 6'h00) && (funct inside {6'h10, 6'h12, 6'h18, 6'h19});
        return (!m_valid || out_ready) && !(m_busy() && in_valid && mulhi) && !m_trap;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0; m_word <= '0; m_ill <= 1'b0; m_trap <= 1'b0;
            m_cyc <= 0; m_has_mult <= 1'b0; m_mult_at <= 0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (in_valid && m_ready()) begin
                m_valid <= 1'b1;
                m_word  <= ref_word(op_code, funct);
                m_ill   <= TRAP && ref_illegal(op_code);
                if (TRAP && ref_illegal(op_code)) m_trap <= 1'b1;
                if (op_code == 6'h00 && (funct == 6'h18 || funct == 6'h19)) begin
                    m_has_mult <= 1'b1;
                    m_mult_at  <= m_cyc + 1;
                end
            end else if (out_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid) check("in_ready", 32'(in_ready), 32'(m_ready()));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            check("mult_busy", 32'(mult_busy), 32'(m_busy()));
            if (m_valid) begin
                check("word", 32'(act_word), 32'(m_word));
                check("illegal_op", 32'(illegal_op), 32'(m_ill));
            end
        end
    end

    task automatic send(input logic [5:0] op, input logic [5:0] fn, output int st);
        in_valid = 1'b1; op_code = op; funct = fn; st = 0;
        @(negedge clk);
        while (!in_ready && st < 50) begin
            st++;
            @(negedge clk);
        end
        if (st >= 50) check("accept_timeout", 32'(st), 32'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; op_code = 6'h08; funct = 6'h00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'(1'b0));
        check("rst_word", 32'(act_word), 32'(17'h0));
        check("rst_busy", 32'(mult_busy), 32'(1'b0));
        check("rst_illegal", 32'(illegal_op), 32'(1'b0));
        #1 rst_n = 1'b1;

        send(6'h08, 6'h00, stalls);
        check("addi_stall", 32'(stalls), 32'(0));
        check("addi_rw", 32'(reg_write), 32'(1'b1));
        check("addi_asa", 32'(alu_src_a), 32'(1'b0));
        check("addi_se", 32'(se_ze), 32'(1'b1));
        check("addi_alu", 32'(alu_mid), 32'(3'b000));
        check("addi_mr", 32'(mem_read), 32'(1'b0));

        send(6'h23, 6'h00, stalls);
        check("lw_stall", 32'(stalls), 32'(0));
        check("lw_mr", 32'(mem_read), 32'(1'b1));
        send(6'h2B, 6'h00, stalls);
        check("sw_stall", 32'(stalls), 32'(0));
        check("sw_mw", 32'(mem_write), 32'(1'b1));
        check("sw_mr", 32'(mem_read), 32'(1'b0));
        send(6'h04, 6'h00, stalls);
        check("beq_stall", 32'(stalls), 32'(0));
        check("beq_bit", 32'(beq), 32'(1'b1));

        send(6'h00, 6'h18, stalls);
        check("mult_start", 32'({start_mult, mult_sign, reg_write}), 32'(3'b110));
        send(6'h00, 6'h10, stalls);
        check("mfhi_stalls", 32'(stalls), 32'(LAT));
        check("mfhi_sel", 32'(out_select), 32'(2'b11));

        send(6'h00, 6'h19, stalls);
        check("multu_start", 32'({start_mult, mult_sign, reg_write}), 32'(3'b100));
        send(6'h00, 6'h20, stalls);
        check("add_nostall", 32'(stalls), 32'(0));
        check("add_alu", 32'(alu_mid), 32'(3'b111));
        send(6'h00, 6'h12, stalls);
        check("mflo_stalls", 32'(stalls), 32'(LAT - 1));
        check("mflo_sel", 32'(out_select), 32'(2'b10));

        // Backpressure: hold ORI for 3 cycles while XORI waits.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(6'h0D, 6'h00, stalls);
        check("ori_stall", 32'(stalls), 32'(0));
        in_valid = 1'b1; op_code = 6'h0E; funct = 6'h00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'(1'b0));
            check("bp_ori_alu", 32'(alu_mid), 32'(3'b011));
            check("bp_out_valid", 32'(out_valid), 32'(1'b1));
        end
        out_ready = 1'b1;
        send(6'h0E, 6'h00, stalls);
        check("xori_stall", 32'(stalls), 32'(0));
        check("xori_alu", 32'(alu_mid), 32'(3'b100));

        // Reset two cycles after a MULT clears the interlock.
        send(6'h00, 6'h18, stalls);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_busy", 32'(mult_busy), 32'(1'b0));
        check("midrst_valid", 32'(out_valid), 32'(1'b0));
        @(negedge clk);
        #1 rst_n = 1'b1;
        send(6'h00, 6'h12, stalls);
        check("midrst_mflo_stall", 32'(stalls), 32'(0));

        // Illegal opcode 111111.
        send(6'h3F, 6'h00, stalls);
        check("ill_stall", 32'(stalls), 32'(0));
        check("ill_word", 32'(act_word), 32'(17'h0));
        check("ill_flag", 32'(illegal_op), 32'(TRAP));
        in_valid = 1'b1; op_code = 6'h08; funct = 6'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("ill_in_ready", 32'(in_ready), 32'(!TRAP));
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b1;
        send(6'h0F, 6'h00, stalls);
        check("post_ill_stall", 32'(stalls), 32'(0));
        check("lui_sel", 32'(out_select), 32'(2'b01));
        send(6'h02, 6'h00, stalls);
        check("j_bit", 32'(jump), 32'(1'b1));
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
